// File: rtl/binary_to_bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter and its seven-segment decoder.
// Lookup patterns are active-low, ordered {g,f,e,d,c,b,a}.
package binary_to_bcd_pkg;

    typedef logic [3:0] bcd_digit_t;
    typedef logic [6:0] seg_pattern_t;

    localparam bcd_digit_t   ADD3_THRESHOLD = 4'd5;
    localparam seg_pattern_t SEG_BLANK      = 7'h7F;

    localparam seg_pattern_t SEG_DIGIT_0 = 7'b1000000;
    localparam seg_pattern_t SEG_DIGIT_1 = 7'b1111001;
    localparam seg_pattern_t SEG_DIGIT_2 = 7'b0100100;
    localparam seg_pattern_t SEG_DIGIT_3 = 7'b0110000;
    localparam seg_pattern_t SEG_DIGIT_4 = 7'b0011001;
    localparam seg_pattern_t SEG_DIGIT_5 = 7'b0010010;
    localparam seg_pattern_t SEG_DIGIT_6 = 7'b0000010;
    localparam seg_pattern_t SEG_DIGIT_7 = 7'b1111000;
    localparam seg_pattern_t SEG_DIGIT_8 = 7'b0000000;
    localparam seg_pattern_t SEG_DIGIT_9 = 7'b0010000;

    // Smallest digit count with 10^d >= 2^w, using log2(10) ~= 3.3219.
    function automatic int min_bcd_digits(input int w);
        int result;
        result = w;
        for (int d = w; d >= 0; d--) begin
            if (d * 33219 >= w * 10000) begin
                result = d;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_to_seven_seg.sv
// Single-digit BCD to active-low seven-segment decoder with a blanking input.
module bcd_to_seven_seg
    import binary_to_bcd_pkg::*;
(
    input  bcd_digit_t   digit,
    input  logic         blank,
    output seg_pattern_t seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg = SEG_DIGIT_0;
                4'd1:    seg = SEG_DIGIT_1;
                4'd2:    seg = SEG_DIGIT_2;
                4'd3:    seg = SEG_DIGIT_3;
                4'd4:    seg = SEG_DIGIT_4;
                4'd5:    seg = SEG_DIGIT_5;
                4'd6:    seg = SEG_DIGIT_6;
                4'd7:    seg = SEG_DIGIT_7;
                4'd8:    seg = SEG_DIGIT_8;
                4'd9:    seg = SEG_DIGIT_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/binary_to_bcd.sv
// Registered double-dabble binary-to-BCD converter, one result per cycle, one cycle latency.
// Define BINARY_TO_BCD_SEG_EN to add the leading-zero-blanked seven-segment output.
module binary_to_bcd
    import binary_to_bcd_pkg::*;
#(
    parameter int BIN_WIDTH = 8,
    parameter int DIGITS    = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [BIN_WIDTH-1:0]   bin,
    input  logic                   bin_valid,
    output logic [4*DIGITS-1:0]    bcd,
`ifdef BINARY_TO_BCD_SEG_EN
    output logic [7*DIGITS-1:0]    seg,
`endif
    output logic                   bcd_valid
);

    localparam int SCRATCH_W = 4*DIGITS + BIN_WIDTH;

    generate
        if (DIGITS < min_bcd_digits(BIN_WIDTH)) begin : g_digits_too_few
            $error("binary_to_bcd: DIGITS too small to represent 2^BIN_WIDTH-1");
        end
    endgenerate

    logic [SCRATCH_W-1:0]  scratch;
    logic [4*DIGITS-1:0]   bcd_next;
    logic [4*DIGITS-1:0]   bcd_reg;
    logic                  bcd_valid_reg;

    // Adjust-then-shift per bit; after the last shift the digits occupy the top of scratch.
    always_comb begin
        scratch = {{(4*DIGITS){1'b0}}, bin};
        for (int i = 0; i < BIN_WIDTH; i++) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (scratch[BIN_WIDTH + 4*d +: 4] >= ADD3_THRESHOLD) begin
                    scratch[BIN_WIDTH + 4*d +: 4] = scratch[BIN_WIDTH + 4*d +: 4] + 4'd3;
                end
            end
            scratch = scratch << 1;
        end
        bcd_next = scratch[SCRATCH_W-1 -: 4*DIGITS];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bcd_reg       <= '0;
            bcd_valid_reg <= 1'b0;
        end else begin
            bcd_valid_reg <= bin_valid;
            if (bin_valid) begin
                bcd_reg <= bcd_next;
            end
        end
    end

    assign bcd       = bcd_reg;
    assign bcd_valid = bcd_valid_reg;

`ifdef BINARY_TO_BCD_SEG_EN
    logic [DIGITS-1:0]    blank;
    logic [7*DIGITS-1:0]  seg_next;
    logic [7*DIGITS-1:0]  seg_reg;
    logic                 higher_zero;

    // A digit blanks only when it and every digit above it are zero; units always shows.
    always_comb begin
        blank       = '0;
        higher_zero = 1'b1;
        for (int d = DIGITS-1; d >= 1; d--) begin
            higher_zero = higher_zero && (bcd_next[4*d +: 4] == 4'd0);
            blank[d]    = higher_zero;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_seg
            bcd_to_seven_seg u_seg (
                .digit (bcd_next[4*gi +: 4]),
                .blank (blank[gi]),
                .seg   (seg_next[7*gi +: 7])
            );
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            seg_reg <= {DIGITS{SEG_BLANK}};
        end else if (bin_valid) begin
            seg_reg <= seg_next;
        end
    end

    assign seg = seg_reg;
`endif

endmodule

// File: tb/tb_binary_to_bcd.sv
// Directed and exhaustive checks of binary_to_bcd at the default 8-bit / 3-digit widths.
// Seven-segment checks are included when BINARY_TO_BCD_SEG_EN is defined.
module tb_binary_to_bcd;

    logic        clock;
    logic        reset;
    logic [7:0]  bin;
    logic        bin_valid;
    logic [11:0] bcd;
    logic        bcd_valid;
`ifdef BINARY_TO_BCD_SEG_EN
    logic [20:0] seg;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    binary_to_bcd #(.BIN_WIDTH(8), .DIGITS(3)) dut (
        .clock     (clock),
        .reset     (reset),
        .bin       (bin),
        .bin_valid (bin_valid),
        .bcd       (bcd),
`ifdef BINARY_TO_BCD_SEG_EN
        .seg       (seg),
`endif
        .bcd_valid (bcd_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive one cycle, then check bcd and bcd_valid against the given expectations.
    task automatic apply(input string tag, input logic rst, input logic vld, input logic [7:0] val,
                         input logic [11:0] exp_bcd, input logic exp_vld);
        reset     = rst;
        bin_valid = vld;
        bin       = val;
        tick();
        $display("%s: reset=%0b valid=%0b bin=%0d -> bcd=%h valid=%0b", tag, rst, vld, val, bcd, bcd_valid);
        check_eq({tag, "_bcd"}, {20'd0, bcd}, {20'd0, exp_bcd});
        check_eq({tag, "_valid"}, {31'd0, bcd_valid}, {31'd0, exp_vld});
    endtask

    function automatic logic [11:0] golden(input int v);
        logic [3:0] h, t, u;
        h = 4'((v / 100) % 10);
        t = 4'((v / 10) % 10);
        u = 4'(v % 10);
        return {h, t, u};
    endfunction

    initial begin
        reset     = 1'b1;
        bin_valid = 1'b1;
        bin       = 8'd200;

        // Reset dominates a valid input
        apply("reset_hold0", 1'b1, 1'b1, 8'd200, 12'h000, 1'b0);
        apply("reset_hold1", 1'b1, 1'b1, 8'd200, 12'h000, 1'b0);
`ifdef BINARY_TO_BCD_SEG_EN
        check_eq("reset_seg", {11'd0, seg}, {11'd0, {3{7'h7F}}});
`endif
        apply("after_reset", 1'b0, 1'b1, 8'd200, 12'h200, 1'b1);

        // Boundaries
        apply("b0",   1'b0, 1'b1, 8'd0,   12'h000, 1'b1);
        apply("b9",   1'b0, 1'b1, 8'd9,   12'h009, 1'b1);
        apply("b10",  1'b0, 1'b1, 8'd10,  12'h010, 1'b1);
        apply("b99",  1'b0, 1'b1, 8'd99,  12'h099, 1'b1);
        apply("b100", 1'b0, 1'b1, 8'd100, 12'h100, 1'b1);
        apply("b255", 1'b0, 1'b1, 8'd255, 12'h255, 1'b1);
        apply("v7",   1'b0, 1'b1, 8'd7,   12'h007, 1'b1);
        apply("v37",  1'b0, 1'b1, 8'd37,  12'h037, 1'b1);
        apply("v128", 1'b0, 1'b1, 8'd128, 12'h128, 1'b1);

        // Hold: invalid input leaves bcd untouched, including an X input
        apply("hold_load", 1'b0, 1'b1, 8'd42, 12'h042, 1'b1);
        apply("hold_77",   1'b0, 1'b0, 8'd77, 12'h042, 1'b0);
        apply("hold_x",    1'b0, 1'b0, 8'hxx, 12'h042, 1'b0);

        // Mid-stream reset
        apply("ms50",  1'b0, 1'b1, 8'd50, 12'h050, 1'b1);
        apply("ms51",  1'b0, 1'b1, 8'd51, 12'h051, 1'b1);
        apply("msrst", 1'b1, 1'b1, 8'd99, 12'h000, 1'b0);
        apply("ms52",  1'b0, 1'b1, 8'd52, 12'h052, 1'b1);

`ifdef BINARY_TO_BCD_SEG_EN
        apply("seg5", 1'b0, 1'b1, 8'd5, 12'h005, 1'b1);
        check_eq("seg5_units",    {25'd0, seg[6:0]},   {25'd0, 7'b0010010});
        check_eq("seg5_tens",     {25'd0, seg[13:7]},  {25'd0, 7'h7F});
        check_eq("seg5_hundreds", {25'd0, seg[20:14]}, {25'd0, 7'h7F});
        apply("seg100", 1'b0, 1'b1, 8'd100, 12'h100, 1'b1);
        check_eq("seg100_units",    {25'd0, seg[6:0]},   {25'd0, 7'b1000000});
        check_eq("seg100_tens",     {25'd0, seg[13:7]},  {25'd0, 7'b1000000});
        check_eq("seg100_hundreds", {25'd0, seg[20:14]}, {25'd0, 7'b1111001});
        apply("seg_hold", 1'b0, 1'b0, 8'd3, 12'h100, 1'b0);
        check_eq("seg_hold_hundreds", {25'd0, seg[20:14]}, {25'd0, 7'b1111001});
        apply("seg0", 1'b0, 1'b1, 8'd0, 12'h000, 1'b1);
        check_eq("seg0_all", {11'd0, seg}, {11'd0, 7'h7F, 7'h7F, 7'b1000000});
`endif

        // Exhaustive back-to-back stream
        for (int v = 0; v < 256; v++) begin
            apply($sformatf("ex%0d", v), 1'b0, 1'b1, 8'(v), golden(v), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
